// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the pre-add alignment and post-add normalize stages.
// Holds widths, the stage FSM encoding and the denormal effective-exponent rule.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int SIG_W   = 24;
  localparam int ALIGN_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Denormals share the exponent of the smallest normal number.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/sticky_rshift.sv
// Combinational right shift of an aligned significand by 0..STEP bits.
// Returns the shifted value and the OR of every bit that fell off the bottom.
module sticky_rshift
  import fp_pkg::*;
#(
  parameter int STEP = 4,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [ALIGN_W-1:0] data_i,
  input  logic [AMT_W-1:0]   amt_i,
  output logic [ALIGN_W-1:0] shifted_o,
  output logic               sticky_o
);

  logic [ALIGN_W-1:0] dropMask;

  assign shifted_o = data_i >> amt_i;
  assign dropMask  = ~({ALIGN_W{1'b1}} << amt_i);
  assign sticky_o  = |(data_i & dropMask);

endmodule

// File: rtl/denormalize_align.sv
// Pre-add alignment: picks the operand with the larger effective exponent and
// right-shifts the other significand STEP bits per cycle, collecting a sticky bit.
module denormalize_align
  import fp_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int MAX_SHIFT = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [SIG_W-1:0]   mantis_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [SIG_W-1:0]   mantis_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_out,
  output logic [ALIGN_W-1:0] mantis_big,
  output logic [ALIGN_W-1:0] mantis_small,
  output logic               sticky,
  output logic               swapped
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);
  localparam int AMT_W = $clog2(STEP + 1);

  state_e             state_q;
  logic [EXP_W-1:0]   exp_q;
  logic [ALIGN_W-1:0] big_q;
  logic [ALIGN_W-1:0] small_q;
  logic               sticky_q;
  logic               swapped_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   rem_q;

  logic [EXP_W-1:0]   effA;
  logic [EXP_W-1:0]   effB;
  logic [EXP_W-1:0]   diffRaw;
  logic [CNT_W-1:0]   diffClamped;
  logic               aBig;
  logic [AMT_W-1:0]   stepAmt;
  logic [ALIGN_W-1:0] small_d;
  logic               dropSticky;

  assign effA        = eff_exp(exp_a);
  assign effB        = eff_exp(exp_b);
  assign aBig        = (effA >= effB);
  assign diffRaw     = aBig ? (effA - effB) : (effB - effA);
  assign diffClamped = (diffRaw > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : CNT_W'(diffRaw);

  // The final shift cycle only moves whatever distance is still outstanding.
  assign stepAmt = (rem_q < CNT_W'(STEP)) ? AMT_W'(rem_q) : AMT_W'(STEP);

  sticky_rshift #(.STEP(STEP)) u_shift (
    .data_i    (small_q),
    .amt_i     (stepAmt),
    .shifted_o (small_d),
    .sticky_o  (dropSticky)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      sticky_q    <= 1'b0;
      swapped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            exp_q     <= aBig ? effA : effB;
            big_q     <= {1'b0, (aBig ? mantis_a : mantis_b), 1'b0};
            small_q   <= {1'b0, (aBig ? mantis_b : mantis_a), 1'b0};
            swapped_q <= ~aBig;
            sticky_q  <= 1'b0;
            rem_q     <= diffClamped;
            if (diffClamped == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          small_q  <= small_d;
          sticky_q <= sticky_q | dropSticky;
          rem_q    <= rem_q - CNT_W'(stepAmt);
          if (rem_q == CNT_W'(stepAmt)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign exp_out      = exp_q;
  assign mantis_big   = big_q;
  assign mantis_small = small_q;
  assign sticky       = sticky_q;
  assign swapped      = swapped_q;

endmodule

// File: tb/tb_denormalize_align.sv
// Bench for denormalize_align with STEP=4: constant vector table, a reference
// model for random operands, a scoreboard queue, and backpressure/reset sequences.
module tb_denormalize_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp_a;
  logic [23:0] mantis_a;
  logic [7:0]  exp_b;
  logic [23:0] mantis_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [25:0] mantis_big;
  logic [25:0] mantis_small;
  logic        sticky;
  logic        swapped;

  int compared;
  int mismatched;

  typedef struct {
    logic [7:0]  ea;
    logic [23:0] ma;
    logic [7:0]  eb;
    logic [23:0] mb;
    logic [7:0]  xExp;
    logic [25:0] xBig;
    logic [25:0] xSmall;
    logic        xSticky;
    logic        xSwapped;
    int          xLat;
  } vec_t;

  vec_t vecs[8];
  vec_t sbq[$];

  denormalize_align #(.STEP(4), .MAX_SHIFT(26)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exp_a        (exp_a),
    .mantis_a     (mantis_a),
    .exp_b        (exp_b),
    .mantis_b     (mantis_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .exp_out      (exp_out),
    .mantis_big   (mantis_big),
    .mantis_small (mantis_small),
    .sticky       (sticky),
    .swapped      (swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Independent reference: wide shift and mask rather than an iterative loop.
  function automatic vec_t model(input logic [7:0] ea, input logic [23:0] ma,
                                 input logic [7:0] eb, input logic [23:0] mb);
    vec_t v;
    int effA, effB, d;
    logic [63:0] smallWide;
    effA = (ea == 0) ? 1 : int'(ea);
    effB = (eb == 0) ? 1 : int'(eb);
    v.ea = ea; v.ma = ma; v.eb = eb; v.mb = mb;
    v.xSwapped = (effB > effA);
    d = v.xSwapped ? effB - effA : effA - effB;
    if (d > 26) d = 26;
    v.xExp = v.xSwapped ? 8'(effB) : 8'(effA);
    v.xBig = v.xSwapped ? {1'b0, mb, 1'b0} : {1'b0, ma, 1'b0};
    smallWide = {38'd0, (v.xSwapped ? ma : mb), 1'b0};
    v.xSmall = 26'(smallWide >> d);
    v.xSticky = |(smallWide & ((64'd1 << d) - 64'd1));
    v.xLat = 1 + (d + 3) / 4;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    exp_a = v.ea; mantis_a = v.ma; exp_b = v.eb; mantis_b = v.mb;
    in_valid = 1'b1;
    @(posedge clk);
    sbq.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    exp_a = 8'hFF; mantis_a = 24'hA5A5A5; exp_b = 8'hEE; mantis_b = 24'h5A5A5A;
  endtask

  // Entered on the first falling edge after accept; hold > 0 adds backpressure.
  task automatic checkOutput(input string tag, input int hold);
    vec_t x;
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    x = sbq.pop_front();
    if (!out_valid) begin
      chk({tag, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(x.xLat));
    chk({tag, "_exp_out"}, 32'(exp_out), 32'(x.xExp));
    chk({tag, "_mantis_big"}, 32'(mantis_big), 32'(x.xBig));
    chk({tag, "_mantis_small"}, 32'(mantis_small), 32'(x.xSmall));
    chk({tag, "_sticky"}, 32'(sticky), 32'(x.xSticky));
    chk({tag, "_swapped"}, 32'(swapped), 32'(x.xSwapped));
    for (int h = 0; h < hold; h++) begin
      exp_a = 8'h01; mantis_a = 24'h123456; exp_b = 8'hF0; mantis_b = 24'h654321;
      in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bp_mantis_small"}, 32'(mantis_small), 32'(x.xSmall));
      chk({tag, "_bp_exp_out"}, 32'(exp_out), 32'(x.xExp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_a = '0; mantis_a = '0; exp_b = '0; mantis_b = '0;

    //          ea     ma          eb     mb          exp    big           small         st    sw    lat
    vecs[0] = '{8'h80, 24'h800000, 8'h80, 24'hC00000, 8'h80, 26'h1000000, 26'h1800000, 1'b0, 1'b0, 1};
    vecs[1] = '{8'h7E, 24'hFFFFFF, 8'h85, 24'h800000, 8'h85, 26'h1000000, 26'h003FFFF, 1'b1, 1'b1, 3};
    vecs[2] = '{8'h10, 24'h800001, 8'h38, 24'hC00000, 8'h38, 26'h1800000, 26'h0000000, 1'b1, 1'b1, 8};
    vecs[3] = '{8'h00, 24'h400000, 8'h01, 24'h800000, 8'h01, 26'h0800000, 26'h1000000, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h85, 24'h800000, 8'h81, 24'h00000F, 8'h85, 26'h1000000, 26'h0000001, 1'b1, 1'b0, 2};
    vecs[5] = '{8'h90, 24'h800000, 8'h80, 24'h000000, 8'h90, 26'h1000000, 26'h0000000, 1'b0, 1'b0, 5};
    vecs[6] = '{8'h9A, 24'h800000, 8'h80, 24'h800000, 8'h9A, 26'h1000000, 26'h0000000, 1'b1, 1'b0, 8};
    vecs[7] = '{8'h41, 24'h800000, 8'h40, 24'h000001, 8'h41, 26'h1000000, 26'h0000001, 1'b0, 1'b0, 2};

    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_mantis_small", 32'(mantis_small), 32'd0);
    chk("reset_exp_out", 32'(exp_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(model(8'($urandom_range(0, 255)), 24'($urandom),
                          8'($urandom_range(0, 255)), 24'($urandom)));
      checkOutput($sformatf("rand%0d", i), 0);
    end

    // Backpressure: extra in_valid pulses while DONE must not be taken.
    applyStimulus(vecs[1]);
    checkOutput("bp", 5);
    repeat (3) @(negedge clk);
    chk("bp_no_extra_op", 32'(out_valid), 32'd0);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a d=20 shift loses the operation.
    applyStimulus(model(8'h94, 24'h800000, 8'h80, 24'hFFFFFF));
    void'(sbq.pop_back());
    @(negedge clk);
    chk("rst_mid_in_shift", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_mantis_small", 32'(mantis_small), 32'd0);
    chk("rst_mid_mantis_big", 32'(mantis_big), 32'd0);
    chk("rst_mid_exp_out", 32'(exp_out), 32'd0);
    chk("rst_mid_sticky", 32'(sticky), 32'd0);
    chk("rst_mid_swapped", 32'(swapped), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(model(8'h70, 24'hABCDEF, 8'h7B, 24'h800000));
    checkOutput("post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
